// File: rtl/set_bit_iterator_if.sv
// rtl/set_bit_iterator_if.sv - word-in / bit-out handshake bundle for set_bit_iterator
// slave is the iterator side; master is the producer/consumer side.
interface set_bit_iterator_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
);
  logic                   word_in_valid;
  logic                   word_in_ready;
  logic [WORD_WIDTH-1:0]  word_in;
  logic                   bit_out_valid;
  logic                   bit_out_ready;
  logic [WORD_WIDTH-1:0]  bit_out_onehot;
  logic [INDEX_WIDTH-1:0] bit_out_index;
  logic                   bit_out_last;
  logic                   busy;

  modport slave (
    input  word_in_valid, word_in, bit_out_ready,
    output word_in_ready, bit_out_valid, bit_out_onehot, bit_out_index,
           bit_out_last, busy
  );

  modport master (
    output word_in_valid, word_in, bit_out_ready,
    input  word_in_ready, bit_out_valid, bit_out_onehot, bit_out_index,
           bit_out_last, busy
  );
endinterface

// File: rtl/set_bit_iterator.sv
// rtl/set_bit_iterator.sv - emits the set bits of a word lowest-first, one per handshake
// Optional SET_BIT_ITERATOR_EMPTY_MARKER_EN turns an accepted zero word into a single empty last beat.
module set_bit_iterator #(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
) (
  input logic              clk_i,
  input logic              rst_n_i,
  set_bit_iterator_if.slave bus
);

  typedef enum logic {IDLE, ITER} state_t;

  state_t                 state_q;
  logic [WORD_WIDTH-1:0]  remaining_q;
  logic                   ready_q;
  logic                   valid_q;
  logic                   busy_q;
  logic [WORD_WIDTH-1:0]  onehot_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   last_q;

  logic [WORD_WIDTH-1:0]  remaining_d;

  function automatic logic [WORD_WIDTH-1:0] lowest_bit(input logic [WORD_WIDTH-1:0] w);
    return w & ~(w - WORD_WIDTH'(1));
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] lowest_index(input logic [WORD_WIDTH-1:0] w);
    logic [INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (w[i]) idx = INDEX_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic logic is_last(input logic [WORD_WIDTH-1:0] w);
    return (w & (w - WORD_WIDTH'(1))) == '0;
  endfunction

  // Word left after the current beat is handed over.
  assign remaining_d = remaining_q & (remaining_q - WORD_WIDTH'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      onehot_q    <= '0;
      index_q     <= '0;
      last_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.word_in_valid && ready_q) begin
            if (bus.word_in != '0) begin
              state_q     <= ITER;
              remaining_q <= bus.word_in;
              ready_q     <= 1'b0;
              valid_q     <= 1'b1;
              busy_q      <= 1'b1;
              onehot_q    <= lowest_bit(bus.word_in);
              index_q     <= lowest_index(bus.word_in);
              last_q      <= is_last(bus.word_in);
            end
`ifdef SET_BIT_ITERATOR_EMPTY_MARKER_EN
            else begin
              // Empty word still gets one marker beat so the consumer sees it.
              state_q     <= ITER;
              remaining_q <= '0;
              ready_q     <= 1'b0;
              valid_q     <= 1'b1;
              busy_q      <= 1'b1;
              onehot_q    <= '0;
              index_q     <= '0;
              last_q      <= 1'b1;
            end
`endif
          end
        end
        ITER: begin
          if (bus.bit_out_ready) begin
            if (last_q) begin
              state_q     <= IDLE;
              remaining_q <= '0;
              ready_q     <= 1'b1;
              valid_q     <= 1'b0;
              busy_q      <= 1'b0;
              onehot_q    <= '0;
              index_q     <= '0;
              last_q      <= 1'b0;
            end else begin
              remaining_q <= remaining_d;
              onehot_q    <= lowest_bit(remaining_d);
              index_q     <= lowest_index(remaining_d);
              last_q      <= is_last(remaining_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.word_in_ready  = ready_q;
  assign bus.bit_out_valid  = valid_q;
  assign bus.busy           = busy_q;
  assign bus.bit_out_onehot = onehot_q;
  assign bus.bit_out_index  = index_q;
  assign bus.bit_out_last   = last_q;

endmodule

// File: tb/tb_set_bit_iterator.sv
// tb/tb_set_bit_iterator.sv - directed bench for set_bit_iterator
module tb_set_bit_iterator;
  localparam int W  = 8;
  localparam int IW = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  set_bit_iterator_if #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) bus ();

  set_bit_iterator #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [7:0] oh, input logic [2:0] idx, input logic last);
    check({tag, ".valid"},  32'(bus.bit_out_valid),  32'd1);
    check({tag, ".onehot"}, 32'(bus.bit_out_onehot), 32'(oh));
    check({tag, ".index"},  32'(bus.bit_out_index),  32'(idx));
    check({tag, ".last"},   32'(bus.bit_out_last),   32'(last));
    check({tag, ".ready"},  32'(bus.word_in_ready),  32'd0);
    check({tag, ".busy"},   32'(bus.busy),           32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(bus.bit_out_valid), 32'd0);
    check({tag, ".ready"}, 32'(bus.word_in_ready), 32'd1);
    check({tag, ".busy"},  32'(bus.busy),          32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.word_in_valid = 1'b0;
    bus.word_in       = '0;
    bus.bit_out_ready = 1'b1;

    #12;
    check_idle("reset");
    check("reset.onehot", 32'(bus.bit_out_onehot), 32'd0);
    check("reset.index",  32'(bus.bit_out_index),  32'd0);
    check("reset.last",   32'(bus.bit_out_last),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA8 with ready held high
    bus.word_in = 8'hA8; bus.word_in_valid = 1'b1;
    @(negedge clk);
    bus.word_in_valid = 1'b0;
    check_beat("a8.b0", 8'h08, 3'd3, 1'b0);
    @(negedge clk);
    check_beat("a8.b1", 8'h20, 3'd5, 1'b0);
    @(negedge clk);
    check_beat("a8.b2", 8'h80, 3'd7, 1'b1);
    @(negedge clk);
    check_idle("a8.done");

    // 0x81 with 4 cycles of backpressure
    bus.word_in = 8'h81; bus.word_in_valid = 1'b1; bus.bit_out_ready = 1'b0;
    @(negedge clk);
    bus.word_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_beat("81.hold", 8'h01, 3'd0, 1'b0);
      @(negedge clk);
    end
    check_beat("81.hold4", 8'h01, 3'd0, 1'b0);
    bus.bit_out_ready = 1'b1;
    @(negedge clk);
    check_beat("81.b1", 8'h80, 3'd7, 1'b1);
    @(negedge clk);
    check_idle("81.done");

    // 0xFF, then 0x02 waiting behind it
    bus.word_in = 8'hFF; bus.word_in_valid = 1'b1;
    @(negedge clk);
    bus.word_in = 8'h02;
    for (int i = 0; i < 8; i++) begin
      check_beat($sformatf("ff.b%0d", i), 8'(1 << i), 3'(i), (i == 7));
      if (i < 7) @(negedge clk);
    end
    @(negedge clk);
    check_idle("ff.gap");
    @(negedge clk);
    bus.word_in_valid = 1'b0;
    check_beat("02.b0", 8'h02, 3'd1, 1'b1);
    @(negedge clk);
    check_idle("02.done");

    // zero word
    bus.word_in = 8'h00; bus.word_in_valid = 1'b1;
    @(negedge clk);
    bus.word_in_valid = 1'b0;
`ifdef SET_BIT_ITERATOR_EMPTY_MARKER_EN
    check_beat("zero.marker", 8'h00, 3'd0, 1'b1);
    @(negedge clk);
    check_idle("zero.done");
`else
    check_idle("zero.drop");
    @(negedge clk);
    check_idle("zero.drop2");
`endif

    // 0x0F with asynchronous reset after two beats
    bus.word_in = 8'h0F; bus.word_in_valid = 1'b1;
    @(negedge clk);
    bus.word_in_valid = 1'b0;
    check_beat("0f.b0", 8'h01, 3'd0, 1'b0);
    @(negedge clk);
    check_beat("0f.b1", 8'h02, 3'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("0f.async_rst");
    check("0f.rst.onehot", 32'(bus.bit_out_onehot), 32'd0);
    rst_n = 1'b1;
    bus.word_in = 8'h10; bus.word_in_valid = 1'b1;
    @(negedge clk);
    bus.word_in_valid = 1'b0;
    check_beat("10.b0", 8'h10, 3'd4, 1'b1);
    @(negedge clk);
    check_idle("10.done");

    // 0x06 while 0x01 is offered throughout
    bus.word_in = 8'h06; bus.word_in_valid = 1'b1;
    @(negedge clk);
    bus.word_in = 8'h01;
    check_beat("06.b0", 8'h02, 3'd1, 1'b0);
    @(negedge clk);
    check_beat("06.b1", 8'h04, 3'd2, 1'b1);
    @(negedge clk);
    check_idle("06.done");
    @(negedge clk);
    bus.word_in_valid = 1'b0;
    check_beat("01.b0", 8'h01, 3'd0, 1'b1);
    @(negedge clk);
    check_idle("01.done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
